// File: rtl/tmds_word_aligner.sv
// TMDS receive word aligner for one channel.
// Slides a 10-bit window over two consecutive raw deserializer words to find the
// symbol boundary. A run of control tokens at one offset declares lock. While
// searching, a long run of non-token words at one offset slips the window by one
// bit. Once locked, a long absence of tokens drops lock and the search resumes
// from the current offset.
module tmds_word_aligner #(
  parameter int LOCK_COUNT     = 8,
  parameter int SEARCH_TIMEOUT = 1024,
  parameter int LOSS_TIMEOUT   = 65536
) (
  input  logic       clk_pixel,
  input  logic       reset,
  input  logic [9:0] raw_word,
  input  logic       raw_valid,
  output logic [9:0] aligned_word,
  output logic       aligned_valid,
  output logic       is_ctrl,
  output logic [1:0] ctrl,
  output logic       locked,
  output logic [3:0] offset,
  output logic       lock_lost
);

  localparam int RUN_W  = $clog2(LOCK_COUNT + 1);
  localparam int TMO_W  = $clog2(SEARCH_TIMEOUT + 1);
  localparam int LOSS_W = $clog2(LOSS_TIMEOUT + 1);

  localparam logic [9:0] TOK_C00 = 10'b1101010100;
  localparam logic [9:0] TOK_C01 = 10'b0010101011;
  localparam logic [9:0] TOK_C10 = 10'b0101010100;
  localparam logic [9:0] TOK_C11 = 10'b1010101011;

  typedef enum logic {ST_SEARCH, ST_LOCKED} state_t;

  // Returns {is_ctrl, c1, c0}; non-token words decode to all zeros.
  function automatic logic [2:0] decode_token(input logic [9:0] w);
    case (w)
      TOK_C00: decode_token = 3'b100;
      TOK_C01: decode_token = 3'b101;
      TOK_C10: decode_token = 3'b110;
      TOK_C11: decode_token = 3'b111;
      default: decode_token = 3'b000;
    endcase
  endfunction

  state_t              state_q, state_d;
  logic [9:0]          prev_word_q, prev_word_d;
  logic [9:0]          aligned_word_q, aligned_word_d;
  logic                aligned_valid_q, aligned_valid_d;
  logic                is_ctrl_q, is_ctrl_d;
  logic [1:0]          ctrl_q, ctrl_d;
  logic [3:0]          offset_q, offset_d;
  logic                lock_lost_q, lock_lost_d;
  logic [RUN_W-1:0]    run_q, run_d;
  logic [TMO_W-1:0]    tmo_q, tmo_d;
  logic [LOSS_W-1:0]   loss_q, loss_d;

  logic [19:0] comb_w;
  logic [19:0] shifted_w;
  logic [9:0]  win;
  logic [2:0]  tok;

  // The current word sits above the previous one, so earlier bits are at lower indices.
  assign comb_w    = {raw_word, prev_word_q};
  assign shifted_w = comb_w >> offset_q;
  assign win       = shifted_w[9:0];
  assign tok       = decode_token(win);

  // Next-state: window capture, token decode and the search/lock counters.
  always_comb begin
    state_d         = state_q;
    prev_word_d     = prev_word_q;
    aligned_word_d  = aligned_word_q;
    aligned_valid_d = 1'b0;
    is_ctrl_d       = is_ctrl_q;
    ctrl_d          = ctrl_q;
    offset_d        = offset_q;
    lock_lost_d     = 1'b0;
    run_d           = run_q;
    tmo_d           = tmo_q;
    loss_d          = loss_q;
    if (raw_valid) begin
      prev_word_d     = raw_word;
      aligned_word_d  = win;
      is_ctrl_d       = tok[2];
      ctrl_d          = tok[1:0];
      aligned_valid_d = 1'b1;
      case (state_q)
        ST_SEARCH: begin
          if (tok[2]) begin
            tmo_d = '0;
            if (run_q == RUN_W'(LOCK_COUNT - 1)) begin
              state_d = ST_LOCKED;
              run_d   = '0;
              loss_d  = '0;
            end else begin
              run_d = run_q + 1'b1;
            end
          end else begin
            run_d = '0;
            if (tmo_q == TMO_W'(SEARCH_TIMEOUT - 1)) begin
              tmo_d    = '0;
              offset_d = (offset_q == 4'd9) ? 4'd0 : offset_q + 4'd1;
            end else begin
              tmo_d = tmo_q + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          // A token in the same word that would hit the limit keeps lock.
          if (tok[2]) begin
            loss_d = '0;
          end else if (loss_q == LOSS_W'(LOSS_TIMEOUT - 1)) begin
            state_d     = ST_SEARCH;
            lock_lost_d = 1'b1;
            loss_d      = '0;
            run_d       = '0;
            tmo_d       = '0;
          end else begin
            loss_d = loss_q + 1'b1;
          end
        end
        default: state_d = ST_SEARCH;
      endcase
    end
  end

  // State register; reset clears every output, the window history and all counters.
  always_ff @(posedge clk_pixel or posedge reset) begin
    if (reset) begin
      state_q         <= ST_SEARCH;
      prev_word_q     <= '0;
      aligned_word_q  <= '0;
      aligned_valid_q <= 1'b0;
      is_ctrl_q       <= 1'b0;
      ctrl_q          <= '0;
      offset_q        <= '0;
      lock_lost_q     <= 1'b0;
      run_q           <= '0;
      tmo_q           <= '0;
      loss_q          <= '0;
    end else begin
      state_q         <= state_d;
      prev_word_q     <= prev_word_d;
      aligned_word_q  <= aligned_word_d;
      aligned_valid_q <= aligned_valid_d;
      is_ctrl_q       <= is_ctrl_d;
      ctrl_q          <= ctrl_d;
      offset_q        <= offset_d;
      lock_lost_q     <= lock_lost_d;
      run_q           <= run_d;
      tmo_q           <= tmo_d;
      loss_q          <= loss_d;
    end
  end

  assign aligned_word  = aligned_word_q;
  assign aligned_valid = aligned_valid_q;
  assign is_ctrl       = is_ctrl_q;
  assign ctrl          = ctrl_q;
  assign locked        = (state_q == ST_LOCKED);
  assign offset        = offset_q;
  assign lock_lost     = lock_lost_q;

endmodule

// File: tb/tb_tmds_word_aligner.sv
// Bench for tmds_word_aligner: a serial symbol stream is delayed by a chosen number
// of bits and cut into raw words; expected outputs go into a queue that a separate
// monitor drains whenever aligned_valid is high.
module tb_tmds_word_aligner;

  localparam int LC = 8;
  localparam int ST = 16;
  localparam int LT = 64;

  localparam logic [9:0] T00 = 10'b1101010100;
  localparam logic [9:0] T01 = 10'b0010101011;
  localparam logic [9:0] T10 = 10'b0101010100;
  localparam logic [9:0] T11 = 10'b1010101011;
  localparam logic [9:0] DAT = 10'b0111110000;

  logic       clk_pixel = 1'b0;
  logic       reset;
  logic [9:0] raw_word;
  logic       raw_valid;
  logic [9:0] aligned_word;
  logic       aligned_valid;
  logic       is_ctrl;
  logic [1:0] ctrl;
  logic       locked;
  logic [3:0] offset;
  logic       lock_lost;

  always #5 clk_pixel = ~clk_pixel;

  tmds_word_aligner #(
    .LOCK_COUNT(LC),
    .SEARCH_TIMEOUT(ST),
    .LOSS_TIMEOUT(LT)
  ) dut (
    .clk_pixel(clk_pixel),
    .reset(reset),
    .raw_word(raw_word),
    .raw_valid(raw_valid),
    .aligned_word(aligned_word),
    .aligned_valid(aligned_valid),
    .is_ctrl(is_ctrl),
    .ctrl(ctrl),
    .locked(locked),
    .offset(offset),
    .lock_lost(lock_lost)
  );

  typedef struct {
    logic [9:0] word;
    logic       chk_word;
    logic       is_ctrl;
    logic [1:0] ctrl;
    logic       locked;
    logic [3:0] offset;
    logic       lost;
    int         test;
    int         idx;
  } exp_t;

  exp_t exp_q[$];

  int vectors = 0;
  int miscompares = 0;

  logic chk_strobe = 1'b0;
  int   chk_mode = 0;

  int         test_id = 0;
  int         word_n = 0;
  int         dly = 0;
  logic       toggle = 1'b0;
  logic [9:0] last_sym = '0;
  logic [9:0] prev_sym = '0;
  logic       prev_isc = 1'b0;
  logic [1:0] prev_c = '0;

  // Monitor: pops on every presented output; strobe requests reset/drain checks.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk_pixel or posedge chk_strobe);
      if (chk_strobe) begin
        vectors++;
        if (chk_mode == 0) begin
          if ({aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, lock_lost} !== 20'd0) begin
            miscompares++;
            $display("FAIL reset_outputs test=%0d: got word=%b vld=%b isc=%b ctrl=%b locked=%b offset=%0d lost=%b, required all zero",
                     test_id, aligned_word, aligned_valid, is_ctrl, ctrl, locked, offset, lock_lost);
          end
        end else begin
          if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL missing_outputs test=%0d: got %0d outputs still expected, required 0",
                     test_id, exp_q.size());
          end
        end
      end else if (aligned_valid) begin
        vectors++;
        if (exp_q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_output test=%0d: got aligned_valid=1 word=%b, required no output",
                   test_id, aligned_word);
        end else begin
          e = exp_q.pop_front();
          if ((e.chk_word && aligned_word !== e.word) || is_ctrl !== e.is_ctrl ||
              ctrl !== e.ctrl || locked !== e.locked || offset !== e.offset ||
              lock_lost !== e.lost) begin
            miscompares++;
            $display("FAIL output test=%0d word#%0d: got word=%b isc=%b ctrl=%b locked=%b offset=%0d lost=%b, required word=%b(chk=%b) isc=%b ctrl=%b locked=%b offset=%0d lost=%b",
                     e.test, e.idx, aligned_word, is_ctrl, ctrl, locked, offset, lock_lost,
                     e.word, e.chk_word, e.is_ctrl, e.ctrl, e.locked, e.offset, e.lost);
          end
        end
      end
    end
  end

  task automatic strobe(input int mode);
    chk_mode = mode;
    chk_strobe = 1'b1;
    #1 chk_strobe = 1'b0;
  endtask

  // Sends one symbol; the window for this word holds the previous symbol when aligned.
  task automatic send(input logic [9:0] sym, input logic s_isc, input logic [1:0] s_c,
                      input logic e_lock, input int e_off, input logic e_lost, input logic chk);
    logic [19:0] pair;
    exp_t e;
    word_n++;
    pair = {sym, last_sym} >> (10 - dly);
    e.word     = prev_sym;
    e.chk_word = chk;
    e.is_ctrl  = chk ? prev_isc : 1'b0;
    e.ctrl     = chk ? prev_c : 2'b00;
    e.locked   = e_lock;
    e.offset   = 4'(e_off);
    e.lost     = e_lost;
    e.test     = test_id;
    e.idx      = word_n;
    exp_q.push_back(e);
    last_sym  = sym;
    prev_sym  = sym;
    prev_isc  = s_isc;
    prev_c    = s_c;
    raw_word  = pair[9:0];
    raw_valid = 1'b1;
    @(negedge clk_pixel);
    if (toggle) begin
      raw_valid = 1'b0;
      raw_word  = 10'h3FF;
      @(negedge clk_pixel);
    end
  endtask

  // Asserts reset mid-cycle with raw_valid possibly still high, checks outputs clear at once.
  task automatic do_reset();
    #1 reset = 1'b1;
    #1 strobe(0);
    strobe(1);
    exp_q.delete();
    raw_valid = 1'b0;
    @(negedge clk_pixel);
    reset    = 1'b0;
    last_sym = '0;
    prev_sym = '0;
    prev_isc = 1'b0;
    prev_c   = '0;
    word_n   = 0;
  endtask

  initial begin
    logic [9:0] toks [4];
    toks[0] = T00;
    toks[1] = T01;
    toks[2] = T10;
    toks[3] = T11;
    reset     = 1'b0;
    raw_valid = 1'b0;
    raw_word  = '0;
    #1 reset = 1'b1;
    #1 strobe(0);
    @(negedge clk_pixel);
    reset = 1'b0;

    // Aligned stream, lock at offset 0 after 8 tokens.
    test_id = 1; dly = 0;
    for (int n = 1; n <= 12; n++) send(T00, 1'b1, 2'b00, n >= 9, 0, 1'b0, 1'b1);
    do_reset();

    // Delay 3: slips every 16 words, locks at offset 3.
    test_id = 2; dly = 3;
    for (int n = 1; n <= 60; n++)
      send(T00, 1'b1, 2'b00, n >= 56, (n >= 48) ? 3 : n / 16, 1'b0, n >= 49);
    do_reset();

    // Delay 7 with cycling tokens: ctrl follows the stream.
    test_id = 3; dly = 7;
    for (int n = 1; n <= 124; n++)
      send(toks[(n - 1) % 4], 1'b1, 2'((n - 1) % 4), n >= 120, (n >= 112) ? 7 : n / 16, 1'b0, n >= 113);
    do_reset();

    // Loss of lock: 63 data words survive, 64 drop lock, then relock.
    test_id = 4; dly = 0;
    for (int n = 1; n <= 10; n++) send(T00, 1'b1, 2'b00, n >= 9, 0, 1'b0, 1'b1);
    for (int n = 11; n <= 73; n++) send(DAT, 1'b0, 2'b00, 1'b1, 0, 1'b0, 1'b1);
    send(T00, 1'b1, 2'b00, 1'b1, 0, 1'b0, 1'b1);
    for (int n = 75; n <= 138; n++) send(DAT, 1'b0, 2'b00, 1'b1, 0, 1'b0, 1'b1);
    for (int n = 139; n <= 148; n++) send(T00, 1'b1, 2'b00, n >= 147, 0, n == 139, 1'b1);
    do_reset();

    // Delay 5 with raw_valid toggling: only valid words count.
    test_id = 5; dly = 5; toggle = 1'b1;
    for (int n = 1; n <= 92; n++)
      send(T00, 1'b1, 2'b00, n >= 88, (n >= 80) ? 5 : n / 16, 1'b0, n >= 81);
    toggle = 1'b0;
    do_reset();

    // Lock at offset 6, reset mid-stream, then relock searching from offset 0.
    test_id = 6; dly = 6;
    for (int n = 1; n <= 106; n++)
      send(T00, 1'b1, 2'b00, n >= 104, (n >= 96) ? 6 : n / 16, 1'b0, n >= 97);
    do_reset();
    dly = 0;
    for (int n = 1; n <= 10; n++) send(T00, 1'b1, 2'b00, n >= 9, 0, 1'b0, 1'b1);
    raw_valid = 1'b0;
    @(negedge clk_pixel);
    strobe(1);
    @(negedge clk_pixel);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
